// File: rtl/dff_bist.sv
// Self-test engine for a single D flip-flop: drives an LFSR stream on dut_d, then checks Q and Q_bar LAT cycles later.
// Define DFF_BIST_FIRST_ERR_EN to add first-failure reporting (first_err_idx / first_err_valid).
module dff_bist #(
  parameter int         NUM_VECTORS = 16,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         LAT         = 2,
  parameter int         ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_q_bar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef DFF_BIST_FIRST_ERR_EN
  output logic [15:0]      first_err_idx,
  output logic             first_err_valid,
`endif
  output logic [1:0]       dbg_state_o
);
  // Handshake: start is a one-cycle request taken only in IDLE or DONE (ignored while busy);
  // done/pass/err_count are valid from entry to DONE until the next accepted start.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0]      NV      = 16'(NUM_VECTORS);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             dut_d_q, dut_d_d;
  logic [15:0]      vec_cnt_q, vec_cnt_d;
  logic [15:0]      cmp_cnt_q, cmp_cnt_d;
  logic [LAT-1:0]   exp_q, exp_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      fe_idx_q, fe_idx_d;
  logic             fe_vld_q, fe_vld_d;

  logic start_ok;
  logic push_bit;
  logic push_vld;
  logic cmp_en;
  logic vec_fail;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    dut_d_d   = dut_d_q;
    vec_cnt_d = vec_cnt_q;
    cmp_cnt_d = cmp_cnt_q;
    err_d     = err_q;
    pass_d    = pass_q;
    fe_idx_d  = fe_idx_q;
    fe_vld_d  = fe_vld_q;
    exp_d     = exp_q;
    vld_d     = vld_q;
    push_bit  = 1'b0;
    push_vld  = 1'b0;
    start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    cmp_en    = ((state_q == S_RUN) || (state_q == S_DRAIN)) && vld_q[LAT-1];
    vec_fail  = (dut_q != exp_q[LAT-1]) || (dut_q_bar == dut_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        dut_d_d = 1'b0;
        // The accepting edge already drives vector 0, so the LFSR holds SEED's successor.
        if (start_ok) begin
          state_d   = S_RUN;
          dut_d_d   = SEED[0];
          lfsr_d    = lfsr_step(SEED);
          push_bit  = SEED[0];
          push_vld  = 1'b1;
          vec_cnt_d = 16'd1;
          cmp_cnt_d = 16'd0;
          err_d     = '0;
          pass_d    = 1'b0;
          fe_idx_d  = 16'hFFFF;
          fe_vld_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (vec_cnt_q == NV) begin
          state_d = S_DRAIN;
          dut_d_d = 1'b0;
        end else begin
          dut_d_d   = lfsr_q[0];
          lfsr_d    = lfsr_step(lfsr_q);
          push_bit  = lfsr_q[0];
          push_vld  = 1'b1;
          vec_cnt_d = vec_cnt_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (cmp_cnt_q == NV) begin
          state_d = S_DONE;
          pass_d  = (err_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cmp_en) begin
      cmp_cnt_d = cmp_cnt_q + 16'd1;
      if (vec_fail) begin
        if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
        if (!fe_vld_q) begin
          fe_idx_d = cmp_cnt_q;
          fe_vld_d = 1'b1;
        end
      end
    end

    // Stage LAT-1 holds the bit driven LAT edges ago, aligned with the dut_q sampled now.
    for (int i = LAT - 1; i > 0; i--) begin
      exp_d[i] = exp_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
    exp_d[0] = push_bit;
    vld_d[0] = push_vld;
    if (start_ok) begin
      vld_d    = '0;
      vld_d[0] = 1'b1;
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      dut_d_q   <= 1'b0;
      vec_cnt_q <= 16'd0;
      cmp_cnt_q <= 16'd0;
      exp_q     <= '0;
      vld_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fe_idx_q  <= 16'hFFFF;
      fe_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      dut_d_q   <= dut_d_d;
      vec_cnt_q <= vec_cnt_d;
      cmp_cnt_q <= cmp_cnt_d;
      exp_q     <= exp_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fe_idx_q  <= fe_idx_d;
      fe_vld_q  <= fe_vld_d;
    end
  end

  assign dut_d       = dut_d_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign dbg_state_o = state_q;

`ifdef DFF_BIST_FIRST_ERR_EN
  assign first_err_idx   = fe_idx_q;
  assign first_err_valid = fe_vld_q;
`else
  logic unused_fe;
  assign unused_fe = ^{fe_idx_q, fe_vld_q};
`endif

endmodule

// File: tb/tb_dff_bist.sv
// Bench for dff_bist: flop model with injectable Q/Q_bar faults, queue-based scoreboard and decoupled monitor.
// Builds with or without DFF_BIST_FIRST_ERR_EN.
module tb_dff_bist;
  localparam int         N     = 16;
  localparam int         LAT   = 2;
  localparam int         N_SAT = 300;
  localparam logic [7:0] SEED  = 8'hA5;

  typedef struct {
    logic [31:0] errs;
    logic        pass;
    logic [15:0] fidx;
    logic        fvld;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_sat;
  always #5 clk = ~clk;

  logic       dut_d, dut_q, dut_q_bar, busy, done, pass;
  logic [7:0] err_count;
  logic [1:0] dbg_state;
  logic       dut_d_s, dut_q_s, dut_q_bar_s, busy_s, done_s, pass_s;
  logic [7:0] err_count_s;
  logic [1:0] dbg_state_s;
`ifdef DFF_BIST_FIRST_ERR_EN
  logic [15:0] fe_idx, fe_idx_s;
  logic        fe_vld, fe_vld_s;
`endif

  dff_bist u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_d(dut_d), .dut_q(dut_q), .dut_q_bar(dut_q_bar),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
`ifdef DFF_BIST_FIRST_ERR_EN
    .first_err_idx(fe_idx), .first_err_valid(fe_vld),
`endif
    .dbg_state_o(dbg_state)
  );

  dff_bist #(.NUM_VECTORS(N_SAT), .ERR_W(8)) u_sat (
    .clk(clk), .rst(rst), .start(start_sat), .dut_d(dut_d_s), .dut_q(dut_q_s), .dut_q_bar(dut_q_bar_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
`ifdef DFF_BIST_FIRST_ERR_EN
    .first_err_idx(fe_idx_s), .first_err_valid(fe_vld_s),
`endif
    .dbg_state_o(dbg_state_s)
  );

  // ---------------- flop-under-test models ----------------
  int          cyc = 0;
  int          start_cyc = -1000;
  int          ff_tag = -1;
  logic        ff_q = 1'b0;
  logic        ff_sat = 1'b0;
  logic [N-1:0] cq = '0;
  logic [N-1:0] cqb = '0;
  logic        fq, fqb;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    ff_q   <= dut_d;
    ff_tag <= cyc - start_cyc - 1;
    ff_sat <= dut_d_s;
  end

  always_comb begin
    fq  = 1'b0;
    fqb = 1'b0;
    if (ff_tag >= 0 && ff_tag < N) begin
      fq  = cq[ff_tag[3:0]];
      fqb = cqb[ff_tag[3:0]];
    end
  end

  assign dut_q       = ff_q ^ fq;
  assign dut_q_bar   = ~dut_q ^ fqb;
  assign dut_q_s     = ~ff_sat;
  assign dut_q_bar_s = ff_sat;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [0:0]  exp_q[$];
  res_t        res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue_run(input logic [N-1:0] m_q, input logic [N-1:0] m_qb);
    logic [7:0] s;
    res_t       r;
    int         nerr;
    s      = SEED;
    nerr   = 0;
    r.fidx = 16'hFFFF;
    r.fvld = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(s[0]);
      s = lfsr_next(s);
      if (m_q[k] || m_qb[k]) begin
        if (!r.fvld) begin
          r.fidx = 16'(k);
          r.fvld = 1'b1;
        end
        nerr++;
      end
    end
    r.errs = (nerr > 255) ? 32'd255 : 32'(nerr);
    r.pass = (nerr == 0);
    res_q.push_back(r);
    @(negedge clk);
    cq        = m_q;
    cqb       = m_qb;
    start_cyc = cyc;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done && !busy) break;
    end
    check("done_timeout", 32'(i < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic stray_start();
    repeat ($urandom_range(1, 12)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- monitor ----------------
  bit   mon_en = 1'b1;
  bit   active = 1'b0;
  int   mon_n = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    res_t r;
    logic [0:0] b;
    if (!rst || !mon_en) begin
      active = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        active = 1'b1;
        mon_n  = 0;
        check("start_clear_done", 32'(done), 32'd0);
        check("start_clear_err", 32'(err_count), 32'd0);
      end
      if (active) begin
        if (busy) begin
          if (mon_n < N) begin
            if (exp_q.size() == 0) begin
              check("unexpected_vector", 32'd1, 32'd0);
            end else begin
              b = exp_q.pop_front();
              check("dut_d_vector", 32'(dut_d), 32'(b));
            end
          end else begin
            check("dut_d_drain_zero", 32'(dut_d), 32'd0);
          end
          mon_n++;
        end else begin
          active = 1'b0;
          check("busy_len", 32'(mon_n), 32'(N + LAT));
          check("done_high", 32'(done), 32'd1);
          if (res_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            r = res_q.pop_front();
            check("err_count", 32'(err_count), r.errs);
            check("pass", 32'(pass), 32'(r.pass));
`ifdef DFF_BIST_FIRST_ERR_EN
            check("first_err_idx", 32'(fe_idx), 32'(r.fidx));
            check("first_err_valid", 32'(fe_vld), 32'(r.fvld));
`endif
          end
        end
      end
    end
    busy_prev = busy;
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    int n_busy;
    logic [N-1:0] m_q, m_qb;
    rst       = 1'b0;
    start     = 1'b1;
    start_sat = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_dut_d", 32'(dut_d), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_sat_busy", 32'(busy_s), 32'd0);
`ifdef DFF_BIST_FIRST_ERR_EN
    check("rst_first_idx", 32'(fe_idx), 32'hFFFF);
    check("rst_first_vld", 32'(fe_vld), 32'd0);
`endif
    start     = 1'b0;
    start_sat = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    issue_run('0, '0);
    wait_done(60);
    issue_run('0, '1);
    wait_done(60);
    issue_run(16'h0020, '0);
    wait_done(60);

    for (int t = 0; t < 6; t++) begin
      m_q  = N'($urandom) & N'($urandom);
      m_qb = N'($urandom) & N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        m_q  = '0;
        m_qb = '0;
      end
      issue_run(m_q, m_qb);
      if ($urandom_range(0, 1) == 1) stray_start();
      wait_done(60);
    end

    issue_run('0, '0);
    stray_start();
    wait_done(60);
    issue_run('0, '0);
    wait_done(60);

    // Abort mid-run: the monitor is paused so this run leaves nothing in the queues.
    mon_en = 1'b0;
    @(negedge clk);
    cq        = '1;
    cqb       = '0;
    start_cyc = cyc;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_pre_err", 32'(err_count), 32'(7 - LAT + 1));
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err_count), 32'd0);
    check("abort_dut_d", 32'(dut_d), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    mon_en = 1'b1;
    issue_run('0, '0);
    wait_done(60);

    // Long run with every vector failing drives err_count into saturation.
    @(negedge clk);
    start_sat = 1'b1;
    @(negedge clk);
    start_sat = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 400 && busy_s; i++) begin
      n_busy++;
      @(negedge clk);
    end
    check("sat_busy_len", 32'(n_busy), 32'(N_SAT + LAT));
    check("sat_done", 32'(done_s), 32'd1);
    check("sat_err", 32'(err_count_s), 32'd255);
    check("sat_pass", 32'(pass_s), 32'd0);
`ifdef DFF_BIST_FIRST_ERR_EN
    check("sat_first_idx", 32'(fe_idx_s), 32'd0);
    check("sat_first_vld", 32'(fe_vld_s), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dff_bist.md
Name: dff_bist

Overview:
- Built-in self-test engine for the single-bit D flip-flop block.
- Drives a pseudo-random stream onto the flop's D input and reads back Q/Q_bar.
- Checks Q against the expected delayed value and Q_bar against ~Q, then reports an error count and pass/fail.
- Sits beside the flop under test: this block owns the far end of the flop's D→Q/Q_bar interface.

Parameters:
- NUM_VECTORS, 16: number of vectors driven and checked per run (1..65535).
- SEED, 8'hA5: LFSR reset/start value; must be nonzero.
- LAT, 2: cycles from a dut_d update to the matching dut_q sample (2 for a posedge flop fed by this block's register); legal 1..4.
- ERR_W, 8: err_count width.

Ports:
- clk  input  1  rising-edge clock, shared with the flop under test.
- rst  input  1  synchronous active-low reset.
- start  input  1  single-cycle run request.
- dut_d  output  1  registered stimulus to the flop's D.
- dut_q  input  1  flop Q.
- dut_q_bar  input  1  flop Q_bar.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE until the next accepted start or reset.
- pass  output  1  valid when done: 1 iff err_count==0.
- err_count  output  ERR_W  failing-vector count, saturating.

Behaviour:
- Reset: rst sampled low at a rising edge forces:
  - state=IDLE, dut_d=0, busy=0, done=0, pass=0, err_count=0;
  - LFSR=SEED; vector and compare counters=0; expected pipeline cleared.
  - Reset mid-RUN or mid-DRAIN aborts immediately; no done is produced.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts left, feedback enters bit0.
  - dut_d is the registered copy of lfsr[0] and is updated each RUN cycle.
  - The LFSR advances once per driven vector.
- States:
  - IDLE: dut_d=0. start=1 → RUN. In the same edge: err_count cleared, LFSR reloaded to SEED, counters cleared.
  - RUN: each cycle drives one vector on dut_d and pushes that bit into a LAT-deep expected shift pipeline with a valid bit. After NUM_VECTORS vectors → DRAIN. dut_d returns to 0 on the edge leaving RUN.
  - DRAIN: no new vectors. Remains until all NUM_VECTORS comparisons have completed (LAT cycles after the last vector) → DONE.
  - DONE: done=1, pass=(err_count==0). start=1 → RUN, with the same clearing as from IDLE; done drops on that edge.
- Compare timing:
  - Vector k is driven at edge e; its comparison is evaluated using dut_q/dut_q_bar as sampled at edge e+LAT.
  - Exactly NUM_VECTORS comparisons are made per run.
  - Comparisons are valid-gated: pipeline bubbles never compare.
- Error rule: a vector fails if dut_q != expected OR dut_q_bar != ~dut_q. Each failing vector adds exactly 1, even if both checks fail.
- Saturation: err_count holds at 2^ERR_W-1. pass is still 0 in that case.
- start while busy: ignored, with no effect on the run.
- start in the same cycle as rst low: reset wins.
- Outputs are registered; no combinational path from dut_q/dut_q_bar to any output.

Optional Feature:
- Macro: DFF_BIST_FIRST_ERR_EN.
- Defined:
  - Adds output first_err_idx (16 bits): index (0-based) of the first failing vector in the current run. Reset/cleared to 16'hFFFF on reset and on each accepted start.
  - Adds output first_err_valid (1 bit): set with the first failure, sticky until reset or the next accepted start.
- Undefined: neither port exists; core behaviour is identical.

Test Plan:
- Golden loopback (bench DFF model, Q_bar=~Q), defaults, start pulse → busy for 16+2 cycles; done=1, pass=1, err_count=0; dut_d sequence matches the LFSR from 8'hA5.
- Q_bar stuck equal to Q (not inverted) → err_count=16, pass=0; with DFF_BIST_FIRST_ERR_EN: first_err_idx=0, first_err_valid=1.
- Single corrupted vector (bench flips Q for vector 5 only) → err_count=1, pass=0; with macro: first_err_idx=5.
- NUM_VECTORS=300, ERR_W=8, Q inverted and Q_bar=~Q → err_count saturates at 255; done=1, pass=0.
- rst low during RUN at vector 7 → next edge: busy=0, done=0, err_count=0, dut_d=0. A following start runs a full clean pass with err_count=0.
- start pulsed during RUN (ignored, vector count unchanged) and again in DONE → second run restarts from SEED; done drops for 18 cycles then returns with pass=1.
